// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle restoring divider for div.w/div.wu/mod.w/mod.wu.
// Rev 1.0 - initial release.
`default_nettype none

module ex_div_unit #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [4:0]        div_op,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] div_result,
  output logic              div_busy
);

  localparam int ITERS = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                is_mod_q, is_mod_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                op_ok;
  logic                op_signed;
  logic [DATA_W:0]     rem_w;
  logic [DATA_W-1:0]   quo_w;

  assign op_ok     = (div_op >= 5'd20) && (div_op <= 5'd23);
  assign op_signed = ~div_op[0];

  // The dividend register doubles as the quotient: each step shifts one
  // dividend bit out of the top and one quotient bit into the bottom.
  always_comb begin
    rem_w = {1'b0, rem_q};
    quo_w = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_w = {rem_w[DATA_W-1:0], quo_w[DATA_W-1]};
      quo_w = {quo_w[DATA_W-2:0], 1'b0};
      if (rem_w >= {1'b0, dvsr_q}) begin
        rem_w    = rem_w - {1'b0, dvsr_q};
        quo_w[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    is_mod_d    = is_mod_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_valid && op_ok && !flush) begin
          state_d   = S_CALC;
          cnt_d     = CNT_W'(ITERS - 1);
          quo_d     = (op_signed && div_src1[DATA_W-1]) ? -div_src1 : div_src1;
          dvsr_d    = (op_signed && div_src2[DATA_W-1]) ? -div_src2 : div_src2;
          rem_d     = '0;
          is_mod_d  = div_op[1];
          neg_quo_d = op_signed && (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
          neg_rem_d = op_signed && div_src1[DATA_W-1];
          dz_d      = (div_src2 == '0);
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_w;
          rem_d = rem_w[DATA_W-1:0];
          if (cnt_q == '0) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
            // Divide-by-zero quotient is all ones regardless of operand signs.
            if (is_mod_q)
              result_d = neg_rem_q ? -rem_w[DATA_W-1:0] : rem_w[DATA_W-1:0];
            else if (dz_q)
              result_d = '1;
            else
              result_d = neg_quo_q ? -quo_w : quo_w;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (flush || res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      is_mod_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      is_mod_q    <= is_mod_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
    end
  end

  assign div_ready  = (state_q == S_IDLE);
  assign div_busy   = (state_q != S_IDLE);
  assign res_valid  = res_valid_q;
  assign div_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: checks ex_div_unit at 1, 2 and 4 bits per cycle in lockstep.
// Rev 1.0 - initial release.
`default_nettype none

module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic [4:0]  div_op = 5'd0;
  logic [31:0] div_src1 = 32'd0;
  logic [31:0] div_src2 = 32'd0;
  logic        res_ready = 1'b0;

  logic [2:0]  rdy, rv, busy;
  logic [31:0] res [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ex_div_unit #(.DATA_W(32), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .div_valid  (div_valid),
      .div_ready  (rdy[g]),
      .div_op     (div_op),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .res_valid  (rv[g]),
      .res_ready  (res_ready),
      .div_result (res[g]),
      .div_busy   (busy[g])
    );
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op == 5'd20 || op == 5'd22) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request; returns just after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    tick();
    div_valid = 1'b0;
    div_op    = 5'(20 + $urandom_range(0, 3));
    div_src1  = $urandom;
    div_src2  = $urandom;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 40 && rv != 3'b111; k++) tick();
    check({name, " done timeout"}, {29'd0, rv}, 32'd7);
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int rise [3];
    for (int i = 0; i < 3; i++) rise[i] = -1;
    start_op(op, a, b);
    check({name, " busy"}, {29'd0, busy}, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      for (int i = 0; i < 3; i++)
        if (rv[i] && rise[i] < 0) rise[i] = k - 1;
      if (k < 33) tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s latency bpc%0d", name, 1 << i), rise[i], 32 >> i);
      check($sformatf("%s result bpc%0d", name, 1 << i), res[i], exp);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, " ready after"}, {29'd0, rdy}, 32'd7);
    check({name, " valid after"}, {29'd0, rv}, 32'd0);
    check({name, " hold after"}, res[0], exp);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bit          seen;

    vecs[0]  = '{5'd20, 32'd7,          32'd2,          32'h0000_0003};
    vecs[1]  = '{5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[2]  = '{5'd22, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[3]  = '{5'd22, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001};
    vecs[4]  = '{5'd21, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF};
    vecs[5]  = '{5'd23, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F};
    vecs[6]  = '{5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[7]  = '{5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[8]  = '{5'd21, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{5'd22, 32'd5,          32'd0,          32'h0000_0005};
    vecs[10] = '{5'd20, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{5'd23, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[12] = '{5'd22, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};

    tick();
    tick();
    reset = 1'b0;
    check("reset ready", {29'd0, rdy}, 32'd7);
    check("reset busy", {29'd0, busy}, 32'd0);
    check("reset valid", {29'd0, rv}, 32'd0);
    check("reset result", res[0], 32'd0);

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 24; i++) begin
      op = 5'(20 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = -($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), op, a, b, ref_model(op, a, b));
    end

    // Backpressure in DONE with a valid request pending.
    start_op(5'd21, 32'd100, 32'd7);
    wait_done("bp");
    div_valid = 1'b1;
    div_op    = 5'd20;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("bp valid c%0d i%0d", c, i), {31'd0, rv[i]}, 32'd1);
        check($sformatf("bp result c%0d i%0d", c, i), res[i], 32'd14);
        check($sformatf("bp ready c%0d i%0d", c, i), {31'd0, rdy[i]}, 32'd0);
      end
    end
    div_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp ready after", {29'd0, rdy}, 32'd7);
    check("bp valid after", {29'd0, rv}, 32'd0);

    // Flush during CALC.
    start_op(5'd20, 32'd1000, 32'd3);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", {29'd0, busy}, 32'd0);
    check("flush ready", {29'd0, rdy}, 32'd7);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rv != 3'b000) seen = 1'b1;
    end
    check("flush no valid", {31'd0, seen}, 32'd0);

    // Reset mid-operation (bpc4 instance already in DONE).
    start_op(5'd21, 32'd100, 32'd7);
    repeat (9) tick();
    check("pre-reset bpc4 valid", {31'd0, rv[2]}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset busy", {29'd0, busy}, 32'd0);
    check("mid reset ready", {29'd0, rdy}, 32'd7);
    check("mid reset valid", {29'd0, rv}, 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("mid reset result i%0d", i), res[i], 32'd0);

    // Unsupported op codes are ignored.
    div_valid = 1'b1;
    div_op    = 5'd0;
    tick();
    check("op0 ignored", {29'd0, busy}, 32'd0);
    div_op = 5'd24;
    tick();
    check("op24 ignored", {29'd0, busy}, 32'd0);
    div_op = 5'd19;
    tick();
    check("op19 ignored", {29'd0, busy}, 32'd0);

    // Flush with a valid request: not accepted.
    div_op = 5'd20;
    flush  = 1'b1;
    tick();
    flush     = 1'b0;
    div_valid = 1'b0;
    check("flush+valid", {29'd0, busy}, 32'd0);

    // Flush together with res_ready in DONE.
    start_op(5'd22, 32'd50, 32'd7);
    wait_done("fr");
    check("fr result", res[0], 32'd1);
    flush     = 1'b1;
    res_ready = 1'b1;
    tick();
    flush     = 1'b0;
    res_ready = 1'b0;
    check("fr ready", {29'd0, rdy}, 32'd7);
    check("fr valid", {29'd0, rv}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
